// File: rtl/sp_banked_ram.sv
// Banked single-port SRAM: byte-strobed writes, 1- or 2-cycle reads,
// per-bank read registers and an optional hardware zero-init sweep.
module sp_banked_ram #(
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned BANK_NUM = 2,
    parameter int unsigned OUT_REG  = 0,
    parameter int unsigned INIT_EN  = 1,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cs_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wdata_strob_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  rvalid_o,
    input  logic                  init_req_i,
    output logic                  init_busy_o
);

    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned ROWS = DEPTH / BANK_NUM;
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned BW   = AW - RW;
    localparam int unsigned SW   = (BW > 0) ? BW : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    localparam state_t RESET_ST = (INIT_EN != 0) ? ST_INIT : ST_IDLE;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_cnt_q, row_cnt_d;
    logic              busy_q;

    logic [SW-1:0]     bank_sel_c;
    logic [RW-1:0]     row_c;
    logic              accept_c;
    logic              rd_acc_c;
    logic              sweep_c;

    logic [SW-1:0]     sel_q;
    logic              rd_vld_q;
    logic [DATA_W-1:0] bank_rd_c [BANK_NUM];

    // Address split: top bits pick the bank, low bits pick the row
    assign row_c = addr_i[RW-1:0];
    if (BW > 0) begin : g_bank_dec
        assign bank_sel_c = addr_i[AW-1 -: BW];
    end else begin : g_single_bank
        assign bank_sel_c = '0;
    end

    assign sweep_c  = (state_q == ST_INIT);
    assign accept_c = cs_i && (state_q == ST_IDLE);
    assign rd_acc_c = accept_c && !we_i;

    // Next-state logic: sweep rows once, counter parks on its last value
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (init_req_i) begin
                    state_d   = ST_INIT;
                    row_cnt_d = '0;
                end
            end
            ST_INIT: begin
                if (row_cnt_q == RW'(ROWS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    row_cnt_d = row_cnt_q + RW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, row counter and registered busy flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= RESET_ST;
            row_cnt_q <= '0;
            busy_q    <= (INIT_EN != 0);
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            busy_q    <= (state_d == ST_INIT);
        end
    end

    assign init_busy_o = busy_q;

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        logic [DATA_W-1:0] mem [ROWS];
        logic [DATA_W-1:0] rd_q;
        logic              bank_en_c;
        logic              wr_en_c;
        logic [RW-1:0]     wr_row_c;
        logic [DATA_W-1:0] wr_data_c;
        logic [NB-1:0]     wr_strob_c;

        assign bank_en_c  = accept_c && (bank_sel_c == SW'(b));
        assign wr_en_c    = sweep_c || (bank_en_c && we_i);
        assign wr_row_c   = sweep_c ? row_cnt_q : row_c;
        assign wr_data_c  = sweep_c ? '0 : wdata_i;
        assign wr_strob_c = sweep_c ? '1 : wdata_strob_i;

        // Byte-strobed array write; the sweep clears every bank in parallel
        always_ff @(posedge clk_i) begin
            if (wr_en_c) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_strob_c[i]) begin
                        mem[wr_row_c][8*i +: 8] <= wr_data_c[8*i +: 8];
                    end
                end
            end
        end

        // Per-bank read register, only updated when this bank is read
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                rd_q <= '0;
            end else if (bank_en_c && !we_i) begin
                rd_q <= mem[row_c];
            end
        end

        assign bank_rd_c[b] = rd_q;
    end

    // Bank-select pipeline follows accepted reads only, so the output holds
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sel_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_acc_c;
            if (rd_acc_c) begin
                sel_q <= bank_sel_c;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] out_q;
        logic              vld_q;

        // Extra output stage, loaded only when a read result arrives
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                out_q <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= rd_vld_q;
                if (rd_vld_q) begin
                    out_q <= bank_rd_c[sel_q];
                end
            end
        end

        assign rdata_o  = out_q;
        assign rvalid_o = vld_q;
    end else begin : g_out_direct
        assign rdata_o  = bank_rd_c[sel_q];
        assign rvalid_o = rd_vld_q;
    end

endmodule

// File: tb/tb_sp_banked_ram.sv
// Directed bench for sp_banked_ram: default geometry in both output modes
// sharing one stimulus bus, plus a 4-bank 64-bit instance for bank decode.
module tb_sp_banked_ram;

    localparam int unsigned DW  = 256;
    localparam int unsigned AWA = 10;
    localparam int unsigned SWA = 32;
    localparam int unsigned DW2 = 64;
    localparam int unsigned AW2 = 8;
    localparam int unsigned SW2 = 8;

    localparam logic [DW-1:0] ZERO = '0;
    localparam logic [DW-1:0] ONES = '1;
    localparam logic [DW-1:0] LO32 = {224'h0, 32'hFFFF_FFFF};
    localparam logic [DW-1:0] A5   = {32{8'hA5}};
    localparam logic [DW-1:0] P11  = {32{8'h11}};
    localparam logic [DW-1:0] P3C  = {32{8'h3C}};
    localparam logic [DW-1:0] MSK  = {4{64'h3C3C3C3C_00000000}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // shared bus for the two default-geometry instances
    logic            rstn;
    logic            cs, we, init_req;
    logic [AWA-1:0]  addr;
    logic [DW-1:0]   wdata;
    logic [SWA-1:0]  strob;
    logic [DW-1:0]   rdata0, rdata1;
    logic            rvalid0, rvalid1, busy0, busy1;

    // small-geometry instance
    logic            b_rstn, b_cs, b_we, b_init_req;
    logic [AW2-1:0]  b_addr;
    logic [DW2-1:0]  b_wdata, b_rdata;
    logic [SW2-1:0]  b_strob;
    logic            b_rvalid, b_busy;

    sp_banked_ram #(.OUT_REG(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .cs_i(cs), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .wdata_strob_i(strob), .rdata_o(rdata0),
        .rvalid_o(rvalid0), .init_req_i(init_req), .init_busy_o(busy0)
    );

    sp_banked_ram #(.OUT_REG(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .cs_i(cs), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .wdata_strob_i(strob), .rdata_o(rdata1),
        .rvalid_o(rvalid1), .init_req_i(init_req), .init_busy_o(busy1)
    );

    sp_banked_ram #(.DATA_W(64), .DEPTH(256), .BANK_NUM(4)) dut2 (
        .clk_i(clk), .rstn_i(b_rstn), .cs_i(b_cs), .we_i(b_we), .addr_i(b_addr),
        .wdata_i(b_wdata), .wdata_strob_i(b_strob), .rdata_o(b_rdata),
        .rvalid_o(b_rvalid), .init_req_i(b_init_req), .init_busy_o(b_busy)
    );

    typedef struct {
        logic           cs;
        logic           we;
        logic [AWA-1:0] addr;
        logic [DW-1:0]  wdata;
        logic [SWA-1:0] strob;
        logic           exp_v;
        logic [DW-1:0]  exp_d;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [AWA-1:0] a,
                         input logic [DW-1:0] d, input logic [SWA-1:0] s);
        cs    = c;
        we    = w;
        addr  = a;
        wdata = d;
        strob = s;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [DW2-1:0] pat(input int a);
        logic [7:0] v;
        v = 8'(a);
        return {v, ~v, v ^ 8'h5A, v + 8'd1, v, ~v, v ^ 8'hA5, v + 8'd3};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [DW-1:0] prev_d;
        logic          prev_v;

        vt[0]  = '{1'b1, 1'b0, 10'h3FF, ZERO, 32'h0,        1'b1, ZERO};
        vt[1]  = '{1'b1, 1'b1, 10'h1FF, ONES, 32'h0000_000F, 1'b0, ZERO};
        vt[2]  = '{1'b1, 1'b0, 10'h1FF, ZERO, 32'h0,        1'b1, LO32};
        vt[3]  = '{1'b1, 1'b0, 10'h3FF, ZERO, 32'h0,        1'b1, ZERO};
        vt[4]  = '{1'b1, 1'b1, 10'h005, A5,   32'hFFFF_FFFF, 1'b0, ZERO};
        vt[5]  = '{1'b1, 1'b0, 10'h005, ZERO, 32'h0,        1'b1, A5};
        vt[6]  = '{1'b0, 1'b0, 10'h000, ZERO, 32'h0,        1'b0, A5};
        vt[7]  = '{1'b1, 1'b1, 10'h005, ZERO, 32'hFFFF_FFFF, 1'b0, A5};
        vt[8]  = '{1'b1, 1'b0, 10'h005, ZERO, 32'h0,        1'b1, ZERO};
        vt[9]  = '{1'b1, 1'b1, 10'h005, P11,  32'h0,        1'b0, ZERO};
        vt[10] = '{1'b1, 1'b0, 10'h005, ZERO, 32'h0,        1'b1, ZERO};
        vt[11] = '{1'b1, 1'b1, 10'h200, P3C,  32'hF0F0_F0F0, 1'b0, ZERO};
        vt[12] = '{1'b1, 1'b0, 10'h000, ZERO, 32'h0,        1'b1, ZERO};
        vt[13] = '{1'b1, 1'b0, 10'h200, ZERO, 32'h0,        1'b1, MSK};
        vt[14] = '{1'b0, 1'b0, 10'h000, ZERO, 32'h0,        1'b0, MSK};

        rstn       = 1'b1;
        b_rstn     = 1'b1;
        init_req   = 1'b0;
        b_init_req = 1'b0;
        b_cs       = 1'b0;
        b_we       = 1'b0;
        b_addr     = '0;
        b_wdata    = '0;
        b_strob    = '0;
        drive(1'b0, 1'b0, '0, ZERO, '0);
        #2;
        rstn   = 1'b0;
        b_rstn = 1'b0;
        #1;

        // reset state
        check("rst rvalid0", DW'(rvalid0), ZERO);
        check("rst rdata0", rdata0, ZERO);
        check("rst rvalid1", DW'(rvalid1), ZERO);
        check("rst rdata1", rdata1, ZERO);
        check("rst busy0", DW'(busy0), DW'(1'b1));
        check("rst busy1", DW'(busy1), DW'(1'b1));

        // power-up sweep length
        @(posedge clk);
        #1;
        rstn = 1'b1;
        count_busy(n);
        check("init sweep cycles", DW'(n), DW'(512));
        check("init busy1 done", DW'(busy1), ZERO);

        // table: dut0 sees results one cycle after accept, dut1 one cycle later
        prev_v = 1'b0;
        prev_d = ZERO;
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].cs, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strob);
            tick();
            check($sformatf("vec%0d rvalid0", i), DW'(rvalid0), DW'(vt[i].exp_v));
            check($sformatf("vec%0d rdata0", i), rdata0, vt[i].exp_d);
            check($sformatf("vec%0d rvalid1", i), DW'(rvalid1), DW'(prev_v));
            check($sformatf("vec%0d rdata1", i), rdata1, prev_d);
            prev_v = vt[i].exp_v;
            prev_d = vt[i].exp_d;
        end

        // hold through idle cycles
        drive(1'b0, 1'b0, '0, ZERO, '0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("hold%0d rdata0", i), rdata0, MSK);
            check($sformatf("hold%0d rdata1", i), rdata1, MSK);
            check($sformatf("hold%0d rvalid1", i), DW'(rvalid1), ZERO);
        end

        // read accepted together with init_req still completes
        drive(1'b1, 1'b0, 10'h1FF, ZERO, '0);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        check("req busy", DW'(busy0), DW'(1'b1));
        check("req rvalid0", DW'(rvalid0), DW'(1'b1));
        check("req rdata0", rdata0, LO32);

        // accesses during the sweep are dropped
        n = 0;
        while (busy0 && n < 2000) begin
            drive(1'b1, n[0], 10'h000, ONES, '1);
            tick();
            n++;
            if (n == 1) begin
                check("req rvalid1", DW'(rvalid1), DW'(1'b1));
                check("req rdata1", rdata1, LO32);
            end
            check($sformatf("drop%0d rvalid0", n), DW'(rvalid0), ZERO);
        end
        drive(1'b0, 1'b0, '0, ZERO, '0);
        check("req sweep cycles", DW'(n), DW'(512));
        check("sweep hold rdata0", rdata0, LO32);
        drive(1'b1, 1'b0, 10'h000, ZERO, '0);
        tick();
        check("post sweep rvalid 000", DW'(rvalid0), DW'(1'b1));
        check("post sweep rdata 000", rdata0, ZERO);
        drive(1'b1, 1'b0, 10'h1FF, ZERO, '0);
        tick();
        check("post sweep rdata 1ff", rdata0, ZERO);

        // reset with a read in flight clears outputs at once
        drive(1'b1, 1'b1, 10'h1FF, ONES, 32'h0000_000F);
        tick();
        drive(1'b1, 1'b0, 10'h1FF, ZERO, '0);
        tick();
        check("pre rst rdata0", rdata0, LO32);
        tick();
        rstn = 1'b0;
        #1;
        drive(1'b0, 1'b0, '0, ZERO, '0);
        check("mid rst rvalid0", DW'(rvalid0), ZERO);
        check("mid rst rdata0", rdata0, ZERO);
        check("mid rst rvalid1", DW'(rvalid1), ZERO);
        check("mid rst rdata1", rdata1, ZERO);
        check("mid rst busy0", DW'(busy0), DW'(1'b1));
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // reset at sweep row 100 restarts the full sweep
        repeat (100) tick();
        check("row100 busy0", DW'(busy0), DW'(1'b1));
        rstn = 1'b0;
        #1;
        check("row100 rst busy0", DW'(busy0), DW'(1'b1));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        count_busy(n);
        check("restart sweep cycles", DW'(n), DW'(512));
        drive(1'b1, 1'b0, 10'h1FF, ZERO, '0);
        tick();
        check("restart rvalid 1ff", DW'(rvalid0), DW'(1'b1));
        check("restart rdata 1ff", rdata0, ZERO);
        drive(1'b0, 1'b0, '0, ZERO, '0);

        // small geometry: 64-row sweep, then full-address bank decode
        @(posedge clk);
        #1;
        b_rstn = 1'b1;
        n = 0;
        while (b_busy && n < 1000) begin
            tick();
            n++;
        end
        check("geo sweep cycles", DW'(n), DW'(64));
        for (int a = 0; a < 256; a++) begin
            b_cs    = 1'b1;
            b_we    = 1'b1;
            b_addr  = AW2'(a);
            b_wdata = pat(a);
            b_strob = '1;
            tick();
        end
        for (int a = 0; a < 256; a++) begin
            b_cs   = 1'b1;
            b_we   = 1'b0;
            b_addr = AW2'(a);
            tick();
            check($sformatf("geo rvalid %0d", a), DW'(b_rvalid), DW'(1'b1));
            check($sformatf("geo rdata %0d", a), DW'(b_rdata), DW'(pat(a)));
        end
        b_cs = 1'b0;
        tick();
        check("geo rvalid idle", DW'(b_rvalid), ZERO);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
